relu_stream_ctrl: RTL and testbench
===================================

Name: relu_stream_ctrl

Overview:
Sequencer for the 8-lane registered ReLU stage in the conv -> ReLU -> pool pipeline. It runs one MAP_X x MAP_Y feature-map frame through that stage:
- flushes the ReLU output registers at frame start;
- gates conv beats with a credit scheme sized to the downstream FIFO;
- emits a valid strobe and (row, col) tags aligned to the 1-cycle ReLU register latency;
- signals frame completion.

It carries no data bits. It only controls and tags the ReLU datapath.

Parameters:
MAP_X, 24, feature-map columns per row
MAP_Y, 24, feature-map rows per frame
CREDITS, 4, downstream FIFO depth (max beats in flight past the ReLU register)
CNT_W, 5, width of column/row counters (must hold MAX(MAP_X,MAP_Y)-1)
CRD_W, 3, width of credit counter (must hold CREDITS)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous assert, active-low (0 = reset)
start  in  1  begin frame; sampled only in IDLE
conv_valid  in  1  conv result beat (all 8 lanes) present this cycle
conv_ready  out  1  controller accepts beat; accept = conv_valid & conv_ready
relu_clr  out  1  synchronous active-high clear to ReLU stage registers
relu_valid  out  1  ReLU outputs hold an accepted beat this cycle (downstream FIFO write)
relu_col  out  CNT_W  column tag of beat at ReLU output
relu_row  out  CNT_W  row tag of beat at ReLU output
relu_last_col  out  1  tagged beat is last of its row
relu_last  out  1  tagged beat is last of frame
fifo_pop  in  1  downstream consumed one entry (credit return)
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at frame completion
err_credit  out  1  sticky: credit return while credits already full

Behaviour:
- Reset (rst=0, async), all held until rst deasserts:
  - state=IDLE; credit=CREDITS; col=row=0; err_credit=0.
  - Outputs: conv_ready=0, relu_clr=0, relu_valid=0, relu_col=relu_row=0, relu_last_col=0, relu_last=0, busy=0, done=0.
- FSM states IDLE, CLEAR, RUN, DRAIN, DONE:
  - IDLE: start=1 -> CLEAR; otherwise stay.
  - CLEAR: relu_clr=1 for exactly this one cycle; col=row=0 -> RUN.
  - RUN: conv_ready = (credit != 0), from registered credit only, no combinational path from fifo_pop. An accept of the beat at col=MAP_X-1, row=MAP_Y-1 -> DRAIN.
  - DRAIN: conv_ready=0; one cycle (last beat now in ReLU register, relu_valid=1, relu_last=1) -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start outside IDLE: ignored. start held high re-triggers a new frame on each return to IDLE (IDLE -> CLEAR next cycle).
- conv_ready=0 in IDLE, CLEAR, DRAIN, DONE regardless of credit.
- Counters, per accept:
  - col = (col==MAP_X-1) ? 0 : col+1;
  - row increments when col wraps.
  - Exactly MAP_X*MAP_Y (576 by default) accepts per frame.
- Tag pipeline, registered on the same edge the ReLU stage captures:
  - relu_valid(t+1) = accept(t).
  - relu_col/relu_row(t+1) = col/row at accept(t).
  - relu_last_col = (col==MAP_X-1); relu_last = last_col & (row==MAP_Y-1).
  - Tags hold their values when relu_valid=0.
- Credit counter:
  - credit_next = credit - accept + fifo_pop.
  - Accept and pop in the same cycle: credit unchanged.
  - fifo_pop with credit==CREDITS and no accept: pop ignored, credit stays CREDITS, err_credit set (sticky until reset).
  - Credit is NOT reloaded on start, because FIFO contents survive frame boundaries.
- Throughput: 1 beat/cycle while credit>0. With no pops, at most CREDITS accepts, then conv_ready=0 until a pop.
- Latency: start -> first possible accept = 2 cycles (CLEAR, then RUN). Last accept -> done pulse = 2 cycles.
- Reset mid-frame: immediate return to IDLE and full credit. Partially streamed frame is abandoned; no done pulse.

Test Plan:
- Reset/idle: rst=0 then 1, no start -> conv_ready=0, relu_valid=0, busy=0, credit=4 (4 accepts possible once running).
- Full frame, pop every cycle: start, conv_valid=1 constant, fifo_pop=relu_valid delayed 1 cycle:
  - relu_clr=1 in exactly 1 cycle;
  - 576 relu_valid beats, tags (0,0)..(23,23) in raster order;
  - relu_last_col on each col=23; relu_last on (23,23) only;
  - done 2 cycles after last accept.
- Backpressure: start, conv_valid=1, fifo_pop=0 -> exactly 4 accepts then conv_ready=0. Single fifo_pop -> exactly one further accept.
- Simultaneous: credit=0 in RUN, pulse fifo_pop -> conv_ready=1 next cycle. Accept and pop same cycle -> credit unchanged.
- Credit error: idle, credit=4, fifo_pop=1 -> err_credit=1 and stays 1, credit stays 4.
- Mid-frame reset and start abuse:
  - rst=0 at beat 100 -> all outputs at reset values, no done.
  - New frame restarts tags at (0,0).
  - start pulsed during RUN -> no effect on counters.

Source files
------------

// File: rtl/relu_stream_if.sv
// Handshake, tag and status bundle between the ReLU sequencer and its
// surroundings. The master side drives frame start, conv beats and FIFO
// credit returns. The slave side is the sequencer.
interface relu_stream_if #(
   parameter int CNT_W = 5
);
   logic             start;
   logic             conv_valid;
   logic             conv_ready;
   logic             relu_clr;
   logic             relu_valid;
   logic [CNT_W-1:0] relu_col;
   logic [CNT_W-1:0] relu_row;
   logic             relu_last_col;
   logic             relu_last;
   logic             fifo_pop;
   logic             busy;
   logic             done;
   logic             err_credit;

   modport master (
      output start, conv_valid, fifo_pop,
      input  conv_ready, relu_clr, relu_valid, relu_col, relu_row,
             relu_last_col, relu_last, busy, done, err_credit
   );

   modport slave (
      input  start, conv_valid, fifo_pop,
      output conv_ready, relu_clr, relu_valid, relu_col, relu_row,
             relu_last_col, relu_last, busy, done, err_credit
   );
endinterface

// File: rtl/relu_stream_ctrl.sv
// Sequencer for the 8-lane registered ReLU stage. It runs one MAP_X x MAP_Y
// frame, gates conv beats against downstream FIFO credit, and tags each beat
// as it leaves the ReLU register. It carries no data bits.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | one-cycle flush of the ReLU output registers, counters zeroed
// RUN   | accepting conv beats while credit remains
// DRAIN | last beat sits in the ReLU register
// DONE  | one-cycle frame-complete pulse
module relu_stream_ctrl #(
   parameter int MAP_X   = 24,
   parameter int MAP_Y   = 24,
   parameter int CREDITS = 4,
   parameter int CNT_W   = 5,
   parameter int CRD_W   = 3
) (
   input logic          clk,
   input logic          rst,
   relu_stream_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(MAP_X - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(MAP_Y - 1);
   localparam logic [CRD_W-1:0] CRD_FULL = CRD_W'(CREDITS);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] col_q, col_d;
   logic [CNT_W-1:0] row_q, row_d;
   logic [CRD_W-1:0] credit_q, credit_d;
   logic             err_q, err_d;
   logic             vld_q, vld_d;
   logic [CNT_W-1:0] tcol_q, tcol_d;
   logic [CNT_W-1:0] trow_q, trow_d;
   logic             tlast_col_q, tlast_col_d;
   logic             tlast_q, tlast_d;

   logic conv_ready;
   logic accept;
   logic col_end;
   logic row_end;

   // Ready depends on registered credit only, so fifo_pop never reaches conv_ready.
   assign conv_ready = (state_q == RUN) && (credit_q != '0);
   assign accept     = bus.conv_valid & conv_ready;
   assign col_end    = (col_q == COL_LAST);
   assign row_end    = (row_q == ROW_LAST);

   // Next-state, raster counters, credit accounting and tag capture.
   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      credit_d    = credit_q;
      err_d       = err_q;
      vld_d       = accept;
      tcol_d      = tcol_q;
      trow_d      = trow_q;
      tlast_col_d = tlast_col_q;
      tlast_d     = tlast_q;

      case (state_q)
         IDLE:  if (bus.start) state_d = CLEAR;
         CLEAR: begin
            col_d   = '0;
            row_d   = '0;
            state_d = RUN;
         end
         RUN:   if (accept && col_end && row_end) state_d = DRAIN;
         DRAIN: state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         tcol_d      = col_q;
         trow_d      = row_q;
         tlast_col_d = col_end;
         tlast_d     = col_end && row_end;
         if (col_end) begin
            col_d = '0;
            row_d = row_end ? '0 : row_q + CNT_W'(1);
         end else begin
            col_d = col_q + CNT_W'(1);
         end
      end

      // A pop with credit already full cannot correspond to a real FIFO entry.
      case ({accept, bus.fifo_pop})
         2'b10: credit_d = credit_q - CRD_W'(1);
         2'b01: begin
            if (credit_q == CRD_FULL) err_d = 1'b1;
            else                      credit_d = credit_q + CRD_W'(1);
         end
         default: credit_d = credit_q;
      endcase
   end

   // State, counters and tag registers; reset abandons any frame in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         col_q       <= '0;
         row_q       <= '0;
         credit_q    <= CRD_FULL;
         err_q       <= 1'b0;
         vld_q       <= 1'b0;
         tcol_q      <= '0;
         trow_q      <= '0;
         tlast_col_q <= 1'b0;
         tlast_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         credit_q    <= credit_d;
         err_q       <= err_d;
         vld_q       <= vld_d;
         tcol_q      <= tcol_d;
         trow_q      <= trow_d;
         tlast_col_q <= tlast_col_d;
         tlast_q     <= tlast_d;
      end
   end

   assign bus.conv_ready    = conv_ready;
   assign bus.relu_clr      = (state_q == CLEAR);
   assign bus.relu_valid    = vld_q;
   assign bus.relu_col      = tcol_q;
   assign bus.relu_row      = trow_q;
   assign bus.relu_last_col = tlast_col_q;
   assign bus.relu_last     = tlast_q;
   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = (state_q == DONE);
   assign bus.err_credit    = err_q;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Directed bench for relu_stream_ctrl: reset values, credit error, back-
// pressure, credit return timing, mid-frame reset and a full popped frame.
module tb_relu_stream_ctrl;
   localparam int MAP_X   = 24;
   localparam int MAP_Y   = 24;
   localparam int CREDITS = 4;
   localparam int CNT_W   = 5;
   localparam int CRD_W   = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   relu_stream_if #(.CNT_W(CNT_W)) bus ();

   relu_stream_ctrl #(
      .MAP_X(MAP_X), .MAP_Y(MAP_Y), .CREDITS(CREDITS),
      .CNT_W(CNT_W), .CRD_W(CRD_W)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_conv_ready"},    32'(bus.conv_ready),    32'd0);
      chk({tag, "_relu_clr"},      32'(bus.relu_clr),      32'd0);
      chk({tag, "_relu_valid"},    32'(bus.relu_valid),    32'd0);
      chk({tag, "_relu_col"},      32'(bus.relu_col),      32'd0);
      chk({tag, "_relu_row"},      32'(bus.relu_row),      32'd0);
      chk({tag, "_relu_last_col"}, 32'(bus.relu_last_col), 32'd0);
      chk({tag, "_relu_last"},     32'(bus.relu_last),     32'd0);
      chk({tag, "_busy"},          32'(bus.busy),          32'd0);
      chk({tag, "_done"},          32'(bus.done),          32'd0);
      chk({tag, "_err_credit"},    32'(bus.err_credit),    32'd0);
   endtask

   initial begin
      int acc;
      int beats;
      int crd;
      int a;
      int p;
      int guard;
      int done_seen;
      int s_cycle;
      int first_acc;
      int last_acc;
      int done_cyc;
      int clr_cnt;
      int done_cnt;
      int last_cnt;
      int lastcol_cnt;
      int exp_col;
      int exp_row;
      int prev_valid;
      bit start_abused;

      bus.start      = 1'b0;
      bus.conv_valid = 1'b0;
      bus.fifo_pop   = 1'b0;

      // Reset held, then released with no start.
      rst = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("rst_hold");
      rst = 1'b1;
      repeat (2) tick();
      chk("idle_conv_ready", 32'(bus.conv_ready), 32'd0);
      chk("idle_busy",       32'(bus.busy),       32'd0);
      chk("idle_relu_valid", 32'(bus.relu_valid), 32'd0);

      // Credit error: pop with full credit while idle.
      bus.fifo_pop = 1'b1;
      tick();
      bus.fifo_pop = 1'b0;
      chk("err_set", 32'(bus.err_credit), 32'd1);
      repeat (3) tick();
      chk("err_sticky", 32'(bus.err_credit), 32'd1);

      // Backpressure: no pops -> exactly CREDITS accepts (credit stayed at 4).
      bus.start      = 1'b1;
      bus.conv_valid = 1'b1;
      tick();
      bus.start = 1'b0;
      chk("bp_clear_cycle",  32'(bus.relu_clr),   32'd1);
      chk("bp_clear_ready",  32'(bus.conv_ready), 32'd0);
      acc = 0;
      repeat (12) begin
         tick();
         if (bus.conv_ready && bus.conv_valid) acc++;
      end
      chk("bp_accepts", 32'(acc), 32'd4);
      chk("bp_stalled", 32'(bus.conv_ready), 32'd0);

      // One pop returns exactly one accept, visible the next cycle.
      bus.fifo_pop = 1'b1;
      tick();
      bus.fifo_pop = 1'b0;
      chk("ready_after_pop", 32'(bus.conv_ready), 32'd1);
      acc = 0;
      repeat (6) begin
         if (bus.conv_ready && bus.conv_valid) acc++;
         tick();
      end
      chk("one_pop_one_accept", 32'(acc), 32'd1);

      // Accept and pop in the same cycle leave credit unchanged (credit=1).
      bus.conv_valid = 1'b0;
      bus.fifo_pop   = 1'b1;
      tick();
      chk("pop_no_accept_ready", 32'(bus.conv_ready), 32'd1);
      bus.conv_valid = 1'b1;
      bus.fifo_pop   = 1'b1;
      tick();
      chk("acc_pop_same_ready", 32'(bus.conv_ready), 32'd1);
      bus.fifo_pop = 1'b0;
      tick();
      chk("credit_was_one", 32'(bus.conv_ready), 32'd0);

      // Stream on to beat 100 with a credit model, then reset mid-frame.
      beats = 7;
      crd   = 0;
      guard = 0;
      while (beats < 100 && guard < 1000) begin
         chk("ready_vs_credit", 32'(bus.conv_ready), 32'(crd != 0));
         a = (bus.conv_ready && bus.conv_valid) ? 1 : 0;
         p = (crd < CREDITS) ? 1 : 0;
         bus.fifo_pop = p[0];
         beats += a;
         crd = crd - a + p;
         guard++;
         tick();
      end
      chk("reached_beat_100", 32'(beats), 32'd100);
      bus.fifo_pop = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk_reset_outputs("mid_rst");
      tick();
      rst = 1'b1;
      bus.conv_valid = 1'b0;
      done_seen = 0;
      repeat (5) begin
         tick();
         if (bus.done) done_seen++;
      end
      chk("mid_rst_no_done", 32'(done_seen), 32'd0);
      chk("mid_rst_idle",    32'(bus.busy),  32'd0);

      // Full frame with pop = relu_valid delayed one cycle; start abused mid-run.
      bus.conv_valid = 1'b1;
      bus.start      = 1'b1;
      s_cycle        = cyc;
      tick();
      bus.start    = 1'b0;
      first_acc    = -1;
      last_acc     = -1;
      done_cyc     = -1;
      clr_cnt      = 0;
      done_cnt     = 0;
      last_cnt     = 0;
      lastcol_cnt  = 0;
      exp_col      = 0;
      exp_row      = 0;
      beats        = 0;
      prev_valid   = 0;
      start_abused = 1'b0;
      guard        = 0;
      while (guard < 2000) begin
         bus.start = 1'b0;
         if (bus.relu_clr) clr_cnt++;
         if (bus.relu_valid) begin
            chk("tag_col", 32'(bus.relu_col), 32'(exp_col));
            chk("tag_row", 32'(bus.relu_row), 32'(exp_row));
            chk("tag_last_col", 32'(bus.relu_last_col), 32'(exp_col == MAP_X - 1));
            chk("tag_last", 32'(bus.relu_last),
                32'((exp_col == MAP_X - 1) && (exp_row == MAP_Y - 1)));
            if (bus.relu_last_col) lastcol_cnt++;
            if (bus.relu_last) last_cnt++;
            beats++;
            if (exp_col == MAP_X - 1) begin
               exp_col = 0;
               exp_row++;
            end else begin
               exp_col++;
            end
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (bus.conv_ready && bus.conv_valid) begin
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
         end
         if (beats == 50 && !start_abused) begin
            bus.start    = 1'b1;
            start_abused = 1'b1;
         end
         bus.fifo_pop = prev_valid[0];
         prev_valid   = bus.relu_valid ? 1 : 0;
         if (done_cnt > 0 && cyc > done_cyc + 2) break;
         guard++;
         tick();
      end
      bus.start      = 1'b0;
      bus.fifo_pop   = 1'b0;
      bus.conv_valid = 1'b0;
      chk("frame_beats",       32'(beats),              32'(MAP_X * MAP_Y));
      chk("frame_clr_cycles",  32'(clr_cnt),            32'd1);
      chk("frame_done_pulses", 32'(done_cnt),           32'd1);
      chk("frame_last_count",  32'(last_cnt),           32'd1);
      chk("frame_lastcol_cnt", 32'(lastcol_cnt),        32'(MAP_Y));
      chk("start_to_accept",   32'(first_acc - s_cycle), 32'd2);
      chk("last_acc_to_done",  32'(done_cyc - last_acc), 32'd2);
      chk("frame_idle_after",  32'(bus.busy),           32'd0);
      chk("tag_hold_col",      32'(bus.relu_col),       32'(MAP_X - 1));
      chk("tag_hold_row",      32'(bus.relu_row),       32'(MAP_Y - 1));
      chk("frame_no_err",      32'(bus.err_credit),     32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
